regfile_scoreboard_bank: RTL and testbench

Parametrised successor to the lab CPU general-register file: a multi-read-port register bank with same-cycle write-to-read bypass, a dedicated condition-flag write path, label/branch operand muxing, and a per-register busy scoreboard for multi-cycle producers. It sits between decode and execute. It supplies operands, and it raises `stall_o` when any operand is still pending from an in-flight producer.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_busy_tracker.sv | 77 +++++++
 rtl/regfile_scoreboard_bank.sv | 137 +++++++++++++
 tb/tb_regfile_scoreboard_bank.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register bank and its busy tracker.
//   V0_IDX         : register read by port 1 for branches in label mode
//   COND_IDX       : condition-flag register, written by the dedicated path
//   ZERO_IDX       : hard-wired zero register
//   DEFAULT_DATA_W : default register width
// Address types are declared inside each module as rf_addr_t, sized by ADDR_W.
package regfile_pkg;

  localparam int V0_IDX         = 4;
  localparam int COND_IDX       = 5;
  localparam int ZERO_IDX       = 6;
  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy scoreboard for multi-cycle producers.
// A bit is set when a producer is issued to that register. It is cleared by
// the data write that retires the producer. When a set and a clear hit the
// same register in one cycle, the set wins, because a newer producer is now
// in flight. Also answers, for each queried address, whether that operand is
// still pending: it is busy and not being written this cycle.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   iss_valid_i   : producer issued this cycle
//   iss_rd_i      : destination of the issued producer
//   wr_en_i       : data write this cycle (clears busy)
//   wr_addr_i     : data write address
//   q_addr_i      : NUM_RD packed query addresses
//   busy_o        : busy vector
//   pend_o        : per-query pending flag
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 2,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     iss_valid_i,
  input  logic [ADDR_W-1:0]        iss_rd_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [NUM_RD*ADDR_W-1:0] q_addr_i,
  output logic [NUM_REGS-1:0]      busy_o,
  output logic [NUM_RD-1:0]        pend_o
);

  typedef logic [ADDR_W-1:0] rf_addr_t;

  localparam rf_addr_t ZERO_A = rf_addr_t'(ZERO_IDX);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // The clear is applied before the set, so a same-cycle set on the same
  // register overrides it.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wr_en_i && (int'(wr_addr_i) < NUM_REGS)) begin
      w_busy_nxt[wr_addr_i] = 1'b0;
    end
    if (iss_valid_i && (iss_rd_i != ZERO_A) && (int'(iss_rd_i) < NUM_REGS)) begin
      w_busy_nxt[iss_rd_i] = 1'b1;
    end
    w_busy_nxt[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Pending = busy and not retired by this cycle's write. The write term lets
  // a stall drop combinationally in the writeback cycle, in step with the
  // data bypass.
  always_comb begin
    pend_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (int'(q_addr_i[k*ADDR_W +: ADDR_W]) < NUM_REGS) begin
        pend_o[k] = r_busy[q_addr_i[k*ADDR_W +: ADDR_W]] &&
                    !(wr_en_i && (wr_addr_i == q_addr_i[k*ADDR_W +: ADDR_W]));
      end
    end
  end

  assign busy_o = r_busy;

endmodule

// File: rtl/regfile_scoreboard_bank.sv
// Multi-read-port general register bank between decode and execute.
// Provides same-cycle write-to-read bypass, a dedicated condition-flag write
// path, label/branch operand muxing and a busy scoreboard. stall_o is raised
// when any operand in use is still owed by an in-flight producer.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   rs_i          : NUM_RD packed read addresses (port k at [k*ADDR_W +: ADDR_W])
//   label_read_i  : label operand mode
//   label_i       : label value (zero-extended on ports 0/1)
//   branch_i      : in label mode, port 1 reads V0 instead of the label
//   wr_en_i, wr_addr_i, wr_data_i : data write
//   cond_we_i, cond_i             : condition-flag write
//   iss_valid_i, iss_rd_i         : multi-cycle producer issue
//   rd_data_o     : NUM_RD packed operands
//   busy_o        : busy vector
//   stall_o       : an operand in use is pending
module regfile_scoreboard_bank
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 2,
  parameter int LABEL_W  = 4,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rs_i,
  input  logic                     label_read_i,
  input  logic [LABEL_W-1:0]       label_i,
  input  logic                     branch_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     cond_we_i,
  input  logic                     cond_i,
  input  logic                     iss_valid_i,
  input  logic [ADDR_W-1:0]        iss_rd_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_REGS-1:0]      busy_o,
  output logic                     stall_o
);

  typedef logic [ADDR_W-1:0] rf_addr_t;

  localparam rf_addr_t V0_A   = rf_addr_t'(V0_IDX);
  localparam rf_addr_t COND_A = rf_addr_t'(COND_IDX);
  localparam rf_addr_t ZERO_A = rf_addr_t'(ZERO_IDX);

  logic [DATA_W-1:0]        r_regs [NUM_REGS];
  logic                     w_data_we;
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [NUM_RD*ADDR_W-1:0] w_eff_addr;
  logic [NUM_RD-1:0]        w_use;
  logic [NUM_RD-1:0]        w_pend;

  // The condition path owns COND_IDX when both writes target it, and the
  // zero register is never stored.
  assign w_data_we = wr_en_i && (wr_addr_i != ZERO_A) &&
                     !(cond_we_i && (wr_addr_i == COND_A)) &&
                     (int'(wr_addr_i) < NUM_REGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_data_we) begin
        r_regs[wr_addr_i] <= wr_data_i;
      end
      if (cond_we_i) begin
        r_regs[COND_IDX] <= DATA_W'(cond_i);
      end
    end
  end

  // Read priority: zero register, then condition bypass, then data bypass,
  // then the array.
  function automatic logic [DATA_W-1:0] read_reg(input rf_addr_t a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (a == ZERO_A) begin
      v = '0;
    end else if (cond_we_i && (a == COND_A)) begin
      v = DATA_W'(cond_i);
    end else if (wr_en_i && (wr_addr_i == a)) begin
      v = wr_data_i;
    end else if (int'(a) < NUM_REGS) begin
      v = r_regs[a];
    end
    return v;
  endfunction

  // w_eff_addr is the register each port actually reads. It feeds the
  // pending query, so that a branch read of V0 stalls on V0.
  always_comb begin
    w_rd_data  = '0;
    w_eff_addr = rs_i;
    w_use      = '1;
    for (int k = 0; k < NUM_RD; k++) begin
      w_rd_data[k*DATA_W +: DATA_W] = read_reg(rs_i[k*ADDR_W +: ADDR_W]);
      if (label_read_i && (k == 0)) begin
        w_rd_data[k*DATA_W +: DATA_W] = DATA_W'(label_i);
        w_use[k]                      = 1'b0;
      end else if (label_read_i && (k == 1)) begin
        if (branch_i) begin
          w_eff_addr[k*ADDR_W +: ADDR_W] = V0_A;
          w_rd_data[k*DATA_W +: DATA_W]  = read_reg(V0_A);
        end else begin
          w_rd_data[k*DATA_W +: DATA_W] = DATA_W'(label_i);
          w_use[k]                      = 1'b0;
        end
      end
    end
  end

  regfile_busy_tracker #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ADDR_W   (ADDR_W)
  ) u_busy (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .q_addr_i    (w_eff_addr),
    .busy_o      (busy_o),
    .pend_o      (w_pend)
  );

  assign rd_data_o = w_rd_data;
  assign stall_o   = |(w_pend & w_use);

endmodule

// File: tb/tb_regfile_scoreboard_bank.sv
// Bench for regfile_scoreboard_bank at default parameters (8 x 8-bit, 2 ports).
// Inputs are driven 1 ns after the rising edge. Expected values are queued
// with the stimulus and compared at the following falling edge.
module tb_regfile_scoreboard_bank;

  localparam int DATA_W = 8;
  localparam int NUM_REGS = 8;
  localparam int NUM_RD = 2;
  localparam int LABEL_W = 4;
  localparam int ADDR_W = 3;

  localparam int SEL_RD0 = 0;
  localparam int SEL_RD1 = 1;
  localparam int SEL_STALL = 2;
  localparam int SEL_BUSY = 3;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_RD*ADDR_W-1:0] rs_i;
  logic                     label_read_i;
  logic [LABEL_W-1:0]       label_i;
  logic                     branch_i;
  logic                     wr_en_i;
  logic [ADDR_W-1:0]        wr_addr_i;
  logic [DATA_W-1:0]        wr_data_i;
  logic                     cond_we_i;
  logic                     cond_i;
  logic                     iss_valid_i;
  logic [ADDR_W-1:0]        iss_rd_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic [NUM_REGS-1:0]      busy_o;
  logic                     stall_o;

  regfile_scoreboard_bank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .LABEL_W  (LABEL_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs_i         (rs_i),
    .label_read_i (label_read_i),
    .label_i      (label_i),
    .branch_i     (branch_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .cond_we_i    (cond_we_i),
    .cond_i       (cond_i),
    .iss_valid_i  (iss_valid_i),
    .iss_rd_i     (iss_rd_i),
    .rd_data_o    (rd_data_o),
    .busy_o       (busy_o),
    .stall_o      (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] m_regs [8];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic exp_push(input string tag, input int sel, input logic [31:0] e);
    exp_t item;
    item.tag = tag;
    item.sel = sel;
    item.exp = e;
    q_exp.push_back(item);
  endtask

  task automatic sample();
    exp_t        item;
    logic [31:0] act;
    while (q_exp.size() > 0) begin
      item = q_exp.pop_front();
      case (item.sel)
        SEL_RD0:   act = 32'(rd_data_o[7:0]);
        SEL_RD1:   act = 32'(rd_data_o[15:8]);
        SEL_STALL: act = 32'(stall_o);
        default:   act = 32'(busy_o);
      endcase
      check_val(item.tag, act, item.exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en_i      = 1'b0;
    cond_we_i    = 1'b0;
    iss_valid_i  = 1'b0;
    label_read_i = 1'b0;
    branch_i     = 1'b0;
  endtask

  task automatic set_rs(input int a0, input int a1);
    rs_i = {3'(a1), 3'(a0)};
  endtask

  task automatic do_write(input int a, input logic [7:0] d);
    wr_en_i   = 1'b1;
    wr_addr_i = 3'(a);
    wr_data_i = d;
  endtask

  task automatic do_issue(input int a);
    iss_valid_i = 1'b1;
    iss_rd_i    = 3'(a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wa;
    int ra;
    logic [7:0] wd;
    logic [7:0] e1;

    rst_n   = 1'b0;
    label_i = '0;
    cond_i  = 1'b0;
    wr_addr_i = '0;
    wr_data_i = '0;
    iss_rd_i  = '0;
    idle();
    set_rs(0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    set_rs(2, 5);
    exp_push("rst_rd0", SEL_RD0, 0);
    exp_push("rst_rd1", SEL_RD1, 0);
    exp_push("rst_busy", SEL_BUSY, 0);
    exp_push("rst_stall", SEL_STALL, 0);
    cycle();

    // Build up state, then reset asynchronously mid-cycle
    idle(); do_write(1, 8'h55); do_issue(3);
    cycle();
    idle(); set_rs(1, 3);
    exp_push("pre_rst_rd0", SEL_RD0, 8'h55);
    exp_push("pre_rst_busy", SEL_BUSY, 8'h08);
    exp_push("pre_rst_stall", SEL_STALL, 1);
    cycle();
    rst_n = 1'b0;
    exp_push("midrst_rd0", SEL_RD0, 0);
    exp_push("midrst_rd1", SEL_RD1, 0);
    exp_push("midrst_busy", SEL_BUSY, 0);
    exp_push("midrst_stall", SEL_STALL, 0);
    cycle();
    rst_n = 1'b1;

    // Write with bypass, then held
    idle(); do_write(2, 8'hA5); set_rs(2, 1);
    exp_push("byp_rd0", SEL_RD0, 8'hA5);
    exp_push("byp_rd1_r1_cleared", SEL_RD1, 0);
    cycle();
    idle(); set_rs(2, 2);
    exp_push("held_rd0", SEL_RD0, 8'hA5);
    exp_push("held_rd1", SEL_RD1, 8'hA5);
    cycle();

    // Zero register
    idle(); do_write(6, 8'hFF); set_rs(6, 6);
    exp_push("zero_byp", SEL_RD0, 0);
    cycle();
    idle(); set_rs(6, 2);
    exp_push("zero_held", SEL_RD0, 0);
    cycle();

    // Condition write beats data write to COND_IDX
    idle(); do_write(5, 8'h3C); cond_we_i = 1'b1; cond_i = 1'b1; set_rs(5, 5);
    exp_push("cond_byp0", SEL_RD0, 8'h01);
    exp_push("cond_byp1", SEL_RD1, 8'h01);
    cycle();
    idle(); cond_i = 1'b0; set_rs(5, 2);
    exp_push("cond_held", SEL_RD0, 8'h01);
    cycle();

    // Label mode
    idle(); do_write(4, 8'h17); set_rs(0, 4);
    exp_push("v0_byp", SEL_RD1, 8'h17);
    cycle();
    idle(); label_read_i = 1'b1; label_i = 4'h9; set_rs(2, 2);
    exp_push("lbl_rd0", SEL_RD0, 8'h09);
    exp_push("lbl_rd1", SEL_RD1, 8'h09);
    cycle();
    idle(); label_read_i = 1'b1; branch_i = 1'b1;
    exp_push("lbl_br_rd0", SEL_RD0, 8'h09);
    exp_push("lbl_br_rd1", SEL_RD1, 8'h17);
    cycle();

    // Scoreboard stall and writeback
    idle(); do_issue(3); set_rs(3, 0);
    exp_push("iss_stall_now", SEL_STALL, 0);
    cycle();
    idle(); set_rs(3, 0);
    exp_push("sb_stall", SEL_STALL, 1);
    exp_push("sb_busy", SEL_BUSY, 8'h08);
    cycle();
    idle(); do_write(3, 8'h42); set_rs(3, 0);
    exp_push("wb_stall", SEL_STALL, 0);
    exp_push("wb_rd0", SEL_RD0, 8'h42);
    exp_push("wb_busy_still", SEL_BUSY, 8'h08);
    cycle();
    idle(); set_rs(3, 0);
    exp_push("after_wb_busy", SEL_BUSY, 0);
    exp_push("after_wb_rd0", SEL_RD0, 8'h42);
    cycle();

    // Label operands never stall; branch read of V0 does
    idle(); do_issue(4); set_rs(0, 0);
    cycle();
    idle(); label_read_i = 1'b1; set_rs(4, 4);
    exp_push("lbl_nostall", SEL_STALL, 0);
    exp_push("lbl_busy_v0", SEL_BUSY, 8'h10);
    cycle();
    idle(); label_read_i = 1'b1; branch_i = 1'b1; set_rs(0, 0);
    exp_push("br_stall", SEL_STALL, 1);
    cycle();
    idle(); label_read_i = 1'b1; branch_i = 1'b1; do_write(4, 8'h17);
    exp_push("br_wb_stall", SEL_STALL, 0);
    exp_push("br_wb_rd1", SEL_RD1, 8'h17);
    cycle();

    // Set/clear collision: set wins, data still written
    idle(); do_issue(1); do_write(1, 8'h66); set_rs(0, 0);
    exp_push("coll_busy_pre", SEL_BUSY, 0);
    cycle();
    idle(); set_rs(1, 0);
    exp_push("coll_busy", SEL_BUSY, 8'h02);
    exp_push("coll_rd0", SEL_RD0, 8'h66);
    exp_push("coll_stall", SEL_STALL, 1);
    cycle();
    idle(); do_write(1, 8'h66);
    cycle();

    // Issue to zero register is ignored
    idle(); do_issue(6); set_rs(6, 0);
    exp_push("ziss_busy_pre", SEL_BUSY, 0);
    cycle();
    idle(); set_rs(6, 6);
    exp_push("ziss_busy", SEL_BUSY, 0);
    exp_push("ziss_stall", SEL_STALL, 0);
    cycle();

    // Randomised writes against a reference array
    m_regs[0] = 8'h00; m_regs[1] = 8'h66; m_regs[2] = 8'hA5; m_regs[3] = 8'h42;
    m_regs[4] = 8'h17; m_regs[5] = 8'h01; m_regs[6] = 8'h00; m_regs[7] = 8'h00;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0: wa = 0;
        1: wa = 1;
        2: wa = 2;
        3: wa = 3;
        4: wa = 4;
        default: wa = 7;
      endcase
      ra = int'($urandom_range(0, 7));
      wd = 8'($urandom);
      if (ra == 6) e1 = 8'h00;
      else if (ra == wa) e1 = wd;
      else e1 = m_regs[ra];
      idle(); do_write(wa, wd); set_rs(wa, ra);
      exp_push("rnd_byp", SEL_RD0, 32'(wd));
      exp_push("rnd_rd1", SEL_RD1, 32'(e1));
      exp_push("rnd_stall", SEL_STALL, 0);
      cycle();
      m_regs[wa] = wd;
    end
    idle(); set_rs(7, 2);
    exp_push("final_r7", SEL_RD0, 32'(m_regs[7]));
    exp_push("final_r2", SEL_RD1, 32'(m_regs[2]));
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
